// File: rtl/simon_pkg.sv
// Shared types and tick-rate constants for the Simon game blocks.
package simon_pkg;

  typedef logic [1:0] lamp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    FIN  = 2'd3
  } seq_state_t;

  // Game logic runs on a 10 kHz tick derived from the board clock by clk_div.
  localparam int unsigned SYS_CLK_HZ = 10_000_000;
  localparam int unsigned TICK_HZ    = 10_000;
  localparam int unsigned TICK_DIV   = SYS_CLK_HZ / TICK_HZ;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/simon_sequencer_tick_timer.sv
// Loadable down-counter; EXPIRED marks the last cycle of a loaded interval.
module tick_timer #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         LOAD,
  input  logic [W-1:0] VAL,
  output logic         EXPIRED
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (LOAD) begin
      cnt <= VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // A load of N therefore spans exactly N cycles before EXPIRED is seen.
  assign EXPIRED = (cnt == W'(1));

endmodule

// File: rtl/simon_sequencer.sv
// Simon pattern store and lamp playback sequencer with fixed on/off timing.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int ON_TICKS  = 5000,
  parameter int OFF_TICKS = 2500
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       CLR,
  input  logic                       APPEND,
  input  logic [1:0]                 RAND,
  input  logic                       PLAY,
  input  logic [$clog2(DEPTH)-1:0]   EXP_IDX,
  output logic [1:0]                 EXP_STEP,
  output logic [$clog2(DEPTH+1)-1:0] LEN,
  output logic                       FULL,
  output logic [1:0]                 OUT,
  output logic                       OUT_ENA,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [1:0]                 DBG_STATE
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(max_int(ON_TICKS, OFF_TICKS) + 1);

  // Commands are single-cycle pulses with no ready: APPEND/PLAY take effect
  // only when sampled in IDLE (APPEND also needs !FULL), otherwise dropped.
  seq_state_t    state, state_nxt;
  logic [IW-1:0] idx, idx_nxt, rd_addr;
  logic [LW-1:0] len;
  lamp_t         out_q, out_nxt;
  lamp_t         mem [DEPTH];
  logic          ena_q, busy_q, done_q;
  logic          append_ok, full, last_step;
  logic          tmr_load, tmr_expired;
  logic [TW-1:0] tmr_val;

  assign full      = (len == LW'(DEPTH));
  assign append_ok = APPEND && !CLR && (state == IDLE) && !full;
  assign last_step = ((LW'(idx) + LW'(1)) == len);
  assign rd_addr   = (state == IDLE) ? '0 : idx + IW'(1);

  tick_timer #(.W(TW)) u_timer (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .LOAD    (tmr_load),
    .VAL     (tmr_val),
    .EXPIRED (tmr_expired)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    out_nxt   = out_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      IDLE: begin
        if (PLAY) begin
          if (len != '0 || append_ok) begin
            state_nxt = ON;
            idx_nxt   = '0;
            tmr_load  = 1'b1;
            tmr_val   = TW'(ON_TICKS);
            // An append in the same cycle lands in slot 0 when empty.
            out_nxt   = (len == '0) ? RAND : mem[rd_addr];
          end else begin
            state_nxt = FIN;
          end
        end
      end
      ON: begin
        if (tmr_expired) begin
          state_nxt = OFF;
          tmr_load  = 1'b1;
          tmr_val   = TW'(OFF_TICKS);
        end
      end
      OFF: begin
        if (tmr_expired) begin
          if (last_step) begin
            state_nxt = FIN;
          end else begin
            state_nxt = ON;
            idx_nxt   = idx + IW'(1);
            tmr_load  = 1'b1;
            tmr_val   = TW'(ON_TICKS);
            out_nxt   = mem[rd_addr];
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (CLR) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      idx    <= '0;
      out_q  <= '0;
      ena_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      len    <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      out_q  <= out_nxt;
      ena_q  <= (state_nxt == ON);
      busy_q <= (state_nxt == ON) || (state_nxt == OFF);
      done_q <= (state_nxt == FIN);
      if (CLR) begin
        len <= '0;
      end else if (append_ok) begin
        len <= len + LW'(1);
      end
    end
  end

  // Pattern storage is deliberately not reset; LEN defines what is valid.
  always_ff @(posedge CLK) begin
    if (append_ok) begin
      mem[len[IW-1:0]] <= RAND;
    end
  end

  assign EXP_STEP  = mem[EXP_IDX];
  assign LEN       = len;
  assign FULL      = full;
  assign OUT       = out_q;
  assign OUT_ENA   = ena_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_simon_sequencer.sv
// Self-checking bench for simon_sequencer against a queue-based playback model.
module tb_simon_sequencer;

  localparam int DEPTH     = 4;
  localparam int ON_TICKS  = 3;
  localparam int OFF_TICKS = 2;
  localparam int PERIOD    = ON_TICKS + OFF_TICKS;
  localparam int W         = 5;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       append;
  logic [1:0] rand_v;
  logic       play;
  logic [1:0] exp_idx;
  logic [1:0] exp_step;
  logic [2:0] len;
  logic       full;
  logic [1:0] out_v;
  logic       out_ena;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  int total_cnt;
  int bad_cnt;

  logic [1:0]   mdl_seq[$];
  logic [W-1:0] exp_q[$];

  simon_sequencer #(
    .DEPTH     (DEPTH),
    .ON_TICKS  (ON_TICKS),
    .OFF_TICKS (OFF_TICKS)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .CLR       (clr),
    .APPEND    (append),
    .RAND      (rand_v),
    .PLAY      (play),
    .EXP_IDX   (exp_idx),
    .EXP_STEP  (exp_step),
    .LEN       (len),
    .FULL      (full),
    .OUT       (out_v),
    .OUT_ENA   (out_ena),
    .BUSY      (busy),
    .DONE      (done),
    .DBG_STATE (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_len();
    check_val("len", 16'(len), 16'(mdl_seq.size()));
    check_val("full", 16'(full), 16'(mdl_seq.size() == DEPTH));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val(tag, {13'd0, out_ena, busy, done}, 16'd0);
  endtask

  // driver tasks
  task automatic do_append(input logic [1:0] v);
    append = 1'b1;
    rand_v = v;
    if (mdl_seq.size() < DEPTH) mdl_seq.push_back(v);
    tick();
    append = 1'b0;
    check_len();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mdl_seq.delete();
    check_len();
    check_idle_outputs("clr_idle");
  endtask

  task automatic check_readback();
    for (int i = 0; i < mdl_seq.size(); i++) begin
      exp_idx = 2'(i);
      #1;
      check_val("exp_step", 16'(exp_step), 16'(mdl_seq[i]));
    end
  endtask

  // Expected per-cycle {done, busy, ena, out} after a PLAY, from step/phase arithmetic.
  task automatic build_expect(input int l);
    logic [W-1:0] e;
    int step, phase;
    exp_q.delete();
    for (int k = 1; k <= l * PERIOD + 1; k++) begin
      if (k <= l * PERIOD) begin
        step  = (k - 1) / PERIOD;
        phase = (k - 1) % PERIOD;
        e = {1'b0, 1'b1, (phase < ON_TICKS), mdl_seq[step]};
      end else begin
        e = {1'b1, 1'b0, 1'b0, (l == 0) ? 2'b00 : mdl_seq[l-1]};
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic play_seq(input bit app, input logic [1:0] v);
    int l;
    logic [W-1:0] e;
    logic [W-1:0] got;
    play   = 1'b1;
    append = app;
    rand_v = v;
    if (app && mdl_seq.size() < DEPTH) mdl_seq.push_back(v);
    l = mdl_seq.size();
    build_expect(l);
    tick();
    play   = 1'b0;
    append = 1'b0;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {done, busy, out_ena, (l == 0) ? 2'b00 : out_v};
      check_val("play", 16'(got), 16'(e));
      if (exp_q.size() > 0) tick();
    end
    tick();
    check_idle_outputs("after_done");
    check_len();
  endtask

  initial begin
    int op;
    logic [1:0] v;
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n   = 1'b0;
    clr     = 1'b0;
    append  = 1'b0;
    rand_v  = 2'd0;
    play    = 1'b0;
    exp_idx = 2'd0;
    repeat (3) tick();
    check_val("rst_out", 16'(out_v), 16'd0);
    check_idle_outputs("rst_flags");
    check_len();
    rst_n = 1'b1;
    tick();

    // empty playback
    play_seq(1'b0, 2'd0);

    // directed three-step pattern
    do_append(2'd2);
    do_append(2'd0);
    do_append(2'd3);
    check_readback();
    play_seq(1'b0, 2'd0);

    // fill and overflow
    do_clr();
    do_append(2'd1);
    do_append(2'd3);
    do_append(2'd2);
    do_append(2'd0);
    do_append(2'd3);
    check_readback();

    // same-cycle append + play
    do_clr();
    do_append(2'd3);
    play_seq(1'b1, 2'd1);
    check_readback();

    // CLR during the second ON interval
    play = 1'b1;
    tick();
    play = 1'b0;
    repeat (PERIOD + 1) tick();
    check_val("clr_mid_ena", 16'(out_ena), 16'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mdl_seq.delete();
    check_idle_outputs("clr_mid");
    check_len();
    for (int i = 0; i < 2 * PERIOD; i++) begin
      tick();
      check_val("no_done_after_clr", 16'(done), 16'd0);
    end
    play_seq(1'b0, 2'd0);

    // async reset in an OFF interval
    do_append(2'd1);
    do_append(2'd2);
    play = 1'b1;
    tick();
    play = 1'b0;
    repeat (ON_TICKS) tick();
    check_val("pre_rst_off", {14'd0, busy, out_ena}, 16'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_out", 16'(out_v), 16'd0);
    check_idle_outputs("async_rst_flags");
    mdl_seq.delete();
    check_len();
    tick();
    rst_n = 1'b1;
    tick();
    do_append(2'd2);
    play_seq(1'b0, 2'd0);

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      v  = 2'($urandom_range(0, 3));
      if (op < 5) begin
        do_append(v);
      end else if (op < 8) begin
        play_seq(1'($urandom_range(0, 1)), v);
      end else if (op == 8) begin
        check_readback();
      end else begin
        do_clr();
      end
    end
    check_readback();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
